keypad_decoder: RTL

KEYPAD_DECODER -- requirements
Module: keypad_decoder

---
 rtl/keypad_decoder_if.sv | 26 ++
 rtl/keypad_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_decoder_if.sv
// Keypad decoder bundle: the keypad matrix lines plus the decoded key outputs.
// The master side is the decoder itself; the slave side is whatever consumes
// the key outputs and drives the column lines (the keypad matrix).
interface keypad_decoder_if;
    logic [3:0] keyPad_col;
    logic [3:0] keyPad_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    modport master (
        input  keyPad_col,
        output keyPad_row,
        output key_code,
        output key_valid,
        output key_pressed
    );

    modport slave (
        output keyPad_col,
        input  keyPad_row,
        input  key_code,
        input  key_valid,
        input  key_pressed
    );
endinterface

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad scanner with full-scan debouncing.
// Rows are driven one-hot active-low, columns are sampled at the end of each
// row slot, and the lowest closed key of every full scan feeds a
// press/release debounce state machine.
module keypad_decoder #(
    parameter int SCAN_DIV       = 250,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic             clock,
    input  logic             reset,
    keypad_decoder_if.master kp
);

    localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_SCANS);
    localparam bit          DEB_ONE    = (DEBOUNCE_SCANS <= 1);

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

    logic [3:0]  col_meta;
    logic [3:0]  col_sync;
    logic [15:0] div_cnt;
    logic [1:0]  row_idx;
    logic        slot_end;
    logic        scan_end;
    logic        col_hit;
    logic [1:0]  col_low;
    logic        acc_found;
    logic [3:0]  acc_code;
    logic        res_found;
    logic [3:0]  res_code;
    logic [1:0]  state;
    logic [3:0]  deb_cnt;
    logic [3:0]  cnt_inc;
    logic [3:0]  cand;
    logic        lock;
    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_pressed_q;

    assign kp.keyPad_row  = ~(4'b0001 << row_idx);
    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_pressed = key_pressed_q;

    assign slot_end = (div_cnt == DIV_LAST);
    assign scan_end = slot_end && (row_idx == 2'd3);

    // Two-flop synchronizer for the asynchronous column lines; resets to "all open".
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= kp.keyPad_col;
            col_sync <= col_meta;
        end
    end

    // Row slot timer: each row stays driven for SCAN_DIV cycles, then the next row.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt <= 16'd0;
            row_idx <= 2'd0;
        end else if (slot_end) begin
            div_cnt <= 16'd0;
            row_idx <= row_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Lowest closed column on the currently driven row.
    always_comb begin
        col_hit = 1'b0;
        col_low = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!col_sync[c]) begin
                col_hit = 1'b1;
                col_low = 2'(c);
            end
        end
    end

    // Rows are visited in ascending order, so the first hit of a scan is its lowest key.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_found <= 1'b0;
            acc_code  <= 4'd0;
        end else if (scan_end) begin
            acc_found <= 1'b0;
            acc_code  <= 4'd0;
        end else if (slot_end && col_hit && !acc_found) begin
            acc_found <= 1'b1;
            acc_code  <= {row_idx, col_low};
        end
    end

    // Full-scan result including the row-3 sample taken on this very cycle.
    always_comb begin
        res_found = acc_found || col_hit;
        res_code  = acc_found ? acc_code : {row_idx, col_low};
        cnt_inc   = (deb_cnt == 4'hF) ? deb_cnt : deb_cnt + 4'd1;
    end

    // Debounce state machine, stepped once per completed scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            deb_cnt       <= 4'd0;
            cand          <= 4'd0;
            lock          <= 1'b0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_end) begin
                // A key that took over from the held key must be let go before it can be accepted.
                lock <= res_found && (lock ||
                        (((state == ST_HELD) || (state == ST_DEB_RELEASE)) && (res_code != key_code_q)));
                case (state)
                    ST_IDLE: begin
                        if (res_found && !lock) begin
                            cand <= res_code;
                            if (DEB_ONE) begin
                                key_code_q    <= res_code;
                                key_valid_q   <= 1'b1;
                                key_pressed_q <= 1'b1;
                                deb_cnt       <= 4'd0;
                                state         <= ST_HELD;
                            end else begin
                                deb_cnt <= 4'd1;
                                state   <= ST_DEB_PRESS;
                            end
                        end
                    end
                    ST_DEB_PRESS: begin
                        if (!res_found) begin
                            deb_cnt <= 4'd0;
                            state   <= ST_IDLE;
                        end else if (res_code == cand) begin
                            if (cnt_inc >= DEB_TARGET) begin
                                key_code_q    <= res_code;
                                key_valid_q   <= 1'b1;
                                key_pressed_q <= 1'b1;
                                deb_cnt       <= 4'd0;
                                state         <= ST_HELD;
                            end else begin
                                deb_cnt <= cnt_inc;
                            end
                        end else begin
                            cand    <= res_code;
                            deb_cnt <= 4'd1;
                        end
                    end
                    ST_HELD: begin
                        if (!(res_found && (res_code == key_code_q))) begin
                            if (DEB_ONE) begin
                                key_pressed_q <= 1'b0;
                                deb_cnt       <= 4'd0;
                                state         <= ST_IDLE;
                            end else begin
                                deb_cnt <= 4'd1;
                                state   <= ST_DEB_RELEASE;
                            end
                        end
                    end
                    default: begin
                        if (res_found && (res_code == key_code_q)) begin
                            deb_cnt <= 4'd0;
                            state   <= ST_HELD;
                        end else if (cnt_inc >= DEB_TARGET) begin
                            key_pressed_q <= 1'b0;
                            deb_cnt       <= 4'd0;
                            state         <= ST_IDLE;
                        end else begin
                            deb_cnt <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

endmodule
